timer_apb_slave: RTL and testbench
==================================

// Module: timer_apb_slave
// PURPOSE
//  APB responder and register file for the timer. Decodes tim_p* transfers and runs a wait-state FSM.
//  Holds control, compare, interrupt and halt registers.
//  Drives the configuration and counter-write strobes to the counter core, and returns its count value.
//  Sits between the APB bus and the counter datapath inside timer_top.
// PARAMETERS
//  WAIT_STATES  1      ACCESS cycles with tim_pready=0 before the completing cycle (0..3)
//  ADDR_W       12     APB address width
// PORTS
//  sys_clk      in   1   single clock, rising edge
//  sys_rst_n    in   1   asynchronous active-low reset
//  tim_psel     in   1   APB select
//  tim_penable  in   1   APB access phase
//  tim_pwrite   in   1   1=write, 0=read
//  tim_paddr    in   12  byte address; bits [1:0] ignored
//  tim_pwdata   in   32  write data
//  tim_pstrb    in   4   write byte enables
//  tim_prdata   out  32  read data, valid only while tim_pready=1, else 0
//  tim_pready   out  1   transfer complete, 1-cycle pulse
//  tim_pslverr  out  1   error, qualified by tim_pready
//  dbg_mode     in   1   debug mode from system
//  cnt_val      in   64  current counter value from core
//  int_set      in   1   compare-match pulse from core
//  timer_en, div_en  out 1  TCR[0], TCR[1]
//  div_val      out  4   TCR[11:8]
//  cmp_val      out  64  {TCMP1,TCMP0}
//  cnt_wr_lo, cnt_wr_hi  out 1  1-cycle pulse: write TDR0 / TDR1 into counter
//  cnt_wdata    out  32  registered tim_pwdata for cnt_wr_*
//  cnt_wstrb    out  4   registered tim_pstrb for cnt_wr_*
//  halt_ack     out  1   THCSR[0] & dbg_mode; core freezes counting when 1
//  tim_int      out  1   TIER[0] & TISR[0]
// BEHAVIOUR
//  FSM states
//   IDLE -> SETUP when psel & !penable.
//   SETUP -> ACCESS when psel & penable.
//   ACCESS holds WAIT_STATES cycles with pready=0, then one cycle with pready=1 -> IDLE.
//  Aborts and violations
//   psel=0 in any non-IDLE state -> IDLE; no write, no pready.
//   penable=1 while in IDLE is ignored.
//  Write and read timing
//   Writes commit at the clock edge ending the pready cycle; the new value is readable on the next transfer.
//   prdata is registered and presented in the pready cycle.
//   cnt_wr_* pulse in the cycle after the pready cycle.
//  Register map (RW fields obey pstrb per byte; reads ignore pstrb)
//   0x000 TCR    [0]en [1]div_en [11:8]div_val; reset 0x0000_0100.
//   0x004/0x008 TDR0/TDR1  read cnt_val[31:0]/[63:32]; a write only pulses cnt_wr_lo/hi.
//   0x00C/0x010 TCMP0/TCMP1  reset 0xFFFF_FFFF.
//   0x014 TIER   [0]int_en; reset 0.
//   0x018 TISR   [0]int_st; W1C; int_set=1 sets it; set wins over simultaneous W1C.
//   0x01C THCSR  [0]halt_req RW, [1]halt_ack RO; reset 0.
//   Unmapped addresses: read 0, writes ignored, pslverr=0.
//  pslverr
//   Asserted with pready on a TCR write when the resulting div_val > 8, OR when en=1 and div_en/div_val would change.
//   An erroring write updates no TCR bit.
//  Reset values
//   All outputs 0 except cmp_val = all ones and div_val = 1.
//  Reset asserted mid-transfer: FSM -> IDLE, pready=0, registers restored, no pending strobe survives.
// TESTING
//  Reset, then read 0x000 and 0x00C -> prdata 0x0000_0100, 0xFFFF_FFFF; pready high 1 cycle after penable (WAIT_STATES=1).
//  Write 0x00C=0x1234_5678 with pstrb 4'b0011, read back -> 0xFFFF_5678.
//  Write TCR=0x0000_0903 (div_val=9) -> pslverr=1 in pready cycle; TCR still reads 0x0000_0100.
//  Write TIER=1; pulse int_set -> tim_int=1 next cycle; W1C TISR=1 same cycle as int_set -> TISR stays 1.
//  Write THCSR=1 with dbg_mode=0 -> halt_ack=0; set dbg_mode=1 -> halt_ack=1, THCSR reads 0x3.
//  Drop psel after SETUP; assert sys_rst_n=0 mid-ACCESS -> no register change, pready stays 0, FSM back in IDLE.

Source files
------------

// File: rtl/timer_apb_slave_if.sv
// APB bus bundle between a requester and the timer register file.
// Requester drives select/enable/address/data; responder returns read data, ready and error.
interface timer_apb_slave_if #(
    parameter int ADDR_W = 12
);
    logic              tim_psel;
    logic              tim_penable;
    logic              tim_pwrite;
    logic [ADDR_W-1:0] tim_paddr;
    logic [31:0]       tim_pwdata;
    logic [3:0]        tim_pstrb;
    logic [31:0]       tim_prdata;
    logic              tim_pready;
    logic              tim_pslverr;

    modport master (
        output tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
        input  tim_prdata, tim_pready, tim_pslverr
    );

    modport slave (
        input  tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
        output tim_prdata, tim_pready, tim_pslverr
    );
endinterface

// File: rtl/timer_apb_slave.sv
// APB responder and timer register file; pready comes WAIT_STATES access cycles after penable.
// Backpressure via registered one-cycle pready; writes commit on the edge that ends the pready cycle.
module timer_apb_slave #(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 12
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    timer_apb_slave_if.slave    apb,
    input  logic                dbg_mode,
    input  logic [63:0]         cnt_val,
    input  logic                int_set,
    output logic                timer_en,
    output logic                div_en,
    output logic [3:0]          div_val,
    output logic [63:0]         cmp_val,
    output logic                cnt_wr_lo,
    output logic                cnt_wr_hi,
    output logic [31:0]         cnt_wdata,
    output logic [3:0]          cnt_wstrb,
    output logic                halt_ack,
    output logic                tim_int
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam int          WORD_W    = ADDR_W - 2;
    localparam logic [31:0] TCR_MASK  = 32'h0000_0F03;
    localparam logic [31:0] TCR_RST   = 32'h0000_0100;
    localparam logic [2:0]  WS        = 3'(WAIT_STATES);

    localparam logic [2:0]  A_TCR     = 3'd0;
    localparam logic [2:0]  A_TDR0    = 3'd1;
    localparam logic [2:0]  A_TDR1    = 3'd2;
    localparam logic [2:0]  A_TCMP0   = 3'd3;
    localparam logic [2:0]  A_TCMP1   = 3'd4;
    localparam logic [2:0]  A_TIER    = 3'd5;
    localparam logic [2:0]  A_TISR    = 3'd6;
    localparam logic [2:0]  A_THCSR   = 3'd7;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_val[8*b +: 8];
        end
        return r;
    endfunction

    state_t        state_q;
    logic [1:0]    wait_q;
    logic          pready_q;
    logic          pslverr_q;
    logic [31:0]   prdata_q;

    logic [31:0]   tcr_q;
    logic [31:0]   tcmp0_q;
    logic [31:0]   tcmp1_q;
    logic          tier_q;
    logic          tisr_q;
    logic          thcsr_q;
    logic          cnt_wr_lo_q;
    logic          cnt_wr_hi_q;
    logic [31:0]   cnt_wdata_q;
    logic [3:0]    cnt_wstrb_q;

    logic [WORD_W-1:0] word;
    logic [2:0]    idx;
    logic          in_map;
    logic          unused_addr_lsb;

    logic [31:0]   rd_data_d;
    logic [31:0]   tcr_d;
    logic          tcr_err;
    logic          resp_err_d;
    logic [2:0]    wait_d;
    logic          commit;
    logic          tisr_clr;

    assign word            = apb.tim_paddr[ADDR_W-1:2];
    assign idx             = word[2:0];
    assign in_map          = (word[WORD_W-1:3] == '0);
    assign unused_addr_lsb = ^apb.tim_paddr[1:0];

    // The bus is held stable from the pready cycle to its closing edge, so the
    // error seen in pready and the commit decision always agree.
    assign commit   = pready_q && apb.tim_psel && apb.tim_penable && apb.tim_pwrite && in_map;
    assign tisr_clr = commit && (idx == A_TISR) && apb.tim_pstrb[0] && apb.tim_pwdata[0];

    always_comb begin
        rd_data_d = '0;
        if (in_map) begin
            case (idx)
                A_TCR:   rd_data_d = tcr_q;
                A_TDR0:  rd_data_d = cnt_val[31:0];
                A_TDR1:  rd_data_d = cnt_val[63:32];
                A_TCMP0: rd_data_d = tcmp0_q;
                A_TCMP1: rd_data_d = tcmp1_q;
                A_TIER:  rd_data_d = {31'd0, tier_q};
                A_TISR:  rd_data_d = {31'd0, tisr_q};
                default: rd_data_d = {30'd0, halt_ack, thcsr_q};
            endcase
        end
    end

    // Divider settings are frozen while the timer runs, and div_val tops out at 8.
    always_comb begin
        tcr_d      = byte_merge(tcr_q, apb.tim_pwdata, apb.tim_pstrb) & TCR_MASK;
        tcr_err    = (tcr_d[11:8] > 4'd8) ||
                     (tcr_q[0] && ((tcr_d[11:8] != tcr_q[11:8]) || (tcr_d[1] != tcr_q[1])));
        resp_err_d = apb.tim_pwrite && in_map && (idx == A_TCR) && tcr_err;
        wait_d     = {1'b0, wait_q} + 3'd1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (apb.tim_psel && !apb.tim_penable) begin
                        state_q <= ST_SETUP;
                        wait_q  <= '0;
                        if (WS == 3'd0) begin
                            pready_q  <= 1'b1;
                            pslverr_q <= resp_err_d;
                            prdata_q  <= apb.tim_pwrite ? 32'd0 : rd_data_d;
                        end
                    end
                end
                ST_SETUP: begin
                    if (!apb.tim_psel) begin
                        state_q <= ST_IDLE;
                    end else if (apb.tim_penable) begin
                        if (pready_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_ACCESS;
                            wait_q  <= 2'd1;
                            if (WS == 3'd1) begin
                                pready_q  <= 1'b1;
                                pslverr_q <= resp_err_d;
                                prdata_q  <= apb.tim_pwrite ? 32'd0 : rd_data_d;
                            end
                        end
                    end else if (pready_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (!apb.tim_psel || !apb.tim_penable || pready_q) begin
                        state_q <= ST_IDLE;
                    end else begin
                        wait_q <= wait_d[1:0];
                        if (wait_d == WS) begin
                            pready_q  <= 1'b1;
                            pslverr_q <= resp_err_d;
                            prdata_q  <= apb.tim_pwrite ? 32'd0 : rd_data_d;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tcr_q       <= TCR_RST;
            tcmp0_q     <= '1;
            tcmp1_q     <= '1;
            tier_q      <= 1'b0;
            tisr_q      <= 1'b0;
            thcsr_q     <= 1'b0;
            cnt_wr_lo_q <= 1'b0;
            cnt_wr_hi_q <= 1'b0;
            cnt_wdata_q <= '0;
            cnt_wstrb_q <= '0;
        end else begin
            cnt_wr_lo_q <= commit && (idx == A_TDR0);
            cnt_wr_hi_q <= commit && (idx == A_TDR1);
            // Interrupt set has priority over a simultaneous write-one-to-clear.
            tisr_q      <= int_set || (tisr_q && !tisr_clr);
            if (commit) begin
                case (idx)
                    A_TCR:   if (!tcr_err) tcr_q <= tcr_d;
                    A_TDR0, A_TDR1: begin
                        cnt_wdata_q <= apb.tim_pwdata;
                        cnt_wstrb_q <= apb.tim_pstrb;
                    end
                    A_TCMP0: tcmp0_q <= byte_merge(tcmp0_q, apb.tim_pwdata, apb.tim_pstrb);
                    A_TCMP1: tcmp1_q <= byte_merge(tcmp1_q, apb.tim_pwdata, apb.tim_pstrb);
                    A_TIER:  if (apb.tim_pstrb[0]) tier_q <= apb.tim_pwdata[0];
                    A_THCSR: if (apb.tim_pstrb[0]) thcsr_q <= apb.tim_pwdata[0];
                    default: ;
                endcase
            end
        end
    end

    assign apb.tim_prdata  = prdata_q;
    assign apb.tim_pready  = pready_q;
    assign apb.tim_pslverr = pslverr_q;

    assign timer_en  = tcr_q[0];
    assign div_en    = tcr_q[1];
    assign div_val   = tcr_q[11:8];
    assign cmp_val   = {tcmp1_q, tcmp0_q};
    assign cnt_wr_lo = cnt_wr_lo_q;
    assign cnt_wr_hi = cnt_wr_hi_q;
    assign cnt_wdata = cnt_wdata_q;
    assign cnt_wstrb = cnt_wstrb_q;
    assign halt_ack  = thcsr_q && dbg_mode;
    assign tim_int   = tier_q && tisr_q;

endmodule

// File: tb/tb_timer_apb_slave.sv
// Directed and randomized APB traffic against a register-level reference model of the timer slave.
module tb_timer_apb_slave;

    localparam int WAIT_STATES = 1;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        dbg_mode;
    logic [63:0] cnt_val;
    logic        int_set;
    logic        timer_en, div_en, cnt_wr_lo, cnt_wr_hi, halt_ack, tim_int;
    logic [3:0]  div_val, cnt_wstrb;
    logic [63:0] cmp_val;
    logic [31:0] cnt_wdata;

    int errors = 0;
    int checks = 0;

    // Reference model state: one variable per architectural register.
    logic [31:0] m_tcr, m_tcmp0, m_tcmp1;
    bit          m_tier, m_tisr, m_thcsr;

    timer_apb_slave_if #(.ADDR_W(12)) bus();

    timer_apb_slave #(.WAIT_STATES(WAIT_STATES), .ADDR_W(12)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .apb       (bus),
        .dbg_mode  (dbg_mode),
        .cnt_val   (cnt_val),
        .int_set   (int_set),
        .timer_en  (timer_en),
        .div_en    (div_en),
        .div_val   (div_val),
        .cmp_val   (cmp_val),
        .cnt_wr_lo (cnt_wr_lo),
        .cnt_wr_hi (cnt_wr_hi),
        .cnt_wdata (cnt_wdata),
        .cnt_wstrb (cnt_wstrb),
        .halt_ack  (halt_ack),
        .tim_int   (tim_int)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    function automatic void model_reset();
        m_tcr = 32'h0000_0100; m_tcmp0 = '1; m_tcmp1 = '1;
        m_tier = 0; m_tisr = 0; m_thcsr = 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a[11:2])
            10'd0:   return m_tcr;
            10'd1:   return cnt_val[31:0];
            10'd2:   return cnt_val[63:32];
            10'd3:   return m_tcmp0;
            10'd4:   return m_tcmp1;
            10'd5:   return {31'd0, m_tier};
            10'd6:   return {31'd0, m_tisr};
            10'd7:   return {30'd0, m_thcsr & dbg_mode, m_thcsr};
            default: return 32'd0;
        endcase
    endfunction

    // Applies a committed write and returns the expected pslverr.
    function automatic bit model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] nt;
        bit          e;
        e = 0;
        case (a[11:2])
            10'd0: begin
                nt = merge(m_tcr, d, s) & 32'h0000_0F03;
                e  = (nt[11:8] > 8) || (m_tcr[0] && (nt[11:8] != m_tcr[11:8] || nt[1] != m_tcr[1]));
                if (!e) m_tcr = nt;
            end
            10'd3: m_tcmp0 = merge(m_tcmp0, d, s);
            10'd4: m_tcmp1 = merge(m_tcmp1, d, s);
            10'd5: if (s[0]) m_tier = d[0];
            10'd6: if (s[0] && d[0]) m_tisr = 0;
            10'd7: if (s[0]) m_thcsr = d[0];
            default: ;
        endcase
        return e;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".timer_en"}, 64'(timer_en), 64'(m_tcr[0]));
        chk({tag, ".div_en"},   64'(div_en),   64'(m_tcr[1]));
        chk({tag, ".div_val"},  64'(div_val),  64'(m_tcr[11:8]));
        chk({tag, ".cmp_val"},  cmp_val,       {m_tcmp1, m_tcmp0});
        chk({tag, ".tim_int"},  64'(tim_int),  64'(m_tier & m_tisr));
        chk({tag, ".halt_ack"}, 64'(halt_ack), 64'(m_thcsr & dbg_mode));
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        bus.tim_psel = 0; bus.tim_penable = 0; bus.tim_pwrite = 0;
        bus.tim_paddr = '0; bus.tim_pwdata = '0; bus.tim_pstrb = '0;
        int_set = 0;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic xfer(input bit wr, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                        input bit pulse_int, output logic [31:0] rdata, output logic err);
        int          n;
        logic [31:0] exp_rd;
        bit          exp_err;
        exp_rd = wr ? 32'd0 : model_read(a);
        @(posedge sys_clk); #1;
        bus.tim_psel = 1; bus.tim_penable = 0; bus.tim_pwrite = wr;
        bus.tim_paddr = a; bus.tim_pwdata = d; bus.tim_pstrb = s;
        @(posedge sys_clk); #1;
        bus.tim_penable = 1;
        n = 0;
        @(negedge sys_clk);
        while (!bus.tim_pready && n < 16) begin
            n++;
            @(negedge sys_clk);
        end
        chk("latency", 64'(n), 64'(WAIT_STATES));
        rdata = bus.tim_prdata;
        err   = bus.tim_pslverr;
        if (pulse_int) int_set = 1;
        exp_err = wr ? model_write(a, d, s) : 1'b0;
        if (pulse_int) m_tisr = 1;
        chk("prdata", 64'(rdata), 64'(exp_rd));
        chk("pslverr", 64'(err), 64'(exp_err));
        @(posedge sys_clk); #1;
        bus.tim_psel = 0; bus.tim_penable = 0; int_set = 0;
        @(negedge sys_clk);
        chk("pready_pulse", 64'(bus.tim_pready), 64'd0);
        chk("cnt_wr_lo", 64'(cnt_wr_lo), 64'(wr && a[11:2] == 10'd1));
        chk("cnt_wr_hi", 64'(cnt_wr_hi), 64'(wr && a[11:2] == 10'd2));
        if (wr && (a[11:2] == 10'd1 || a[11:2] == 10'd2)) begin
            chk("cnt_wdata", 64'(cnt_wdata), 64'(d));
            chk("cnt_wstrb", 64'(cnt_wstrb), 64'(s));
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [11:0] addrs [11];
        dbg_mode = 0;
        cnt_val  = 64'h0123_4567_89AB_CDEF;
        do_reset();

        @(negedge sys_clk);
        chk("rst.pready", 64'(bus.tim_pready), 64'd0);
        chk("rst.prdata", 64'(bus.tim_prdata), 64'd0);
        chk("rst.cnt_wr", 64'({cnt_wr_lo, cnt_wr_hi}), 64'd0);
        chk("rst.cnt_wdata", 64'(cnt_wdata), 64'd0);
        check_outputs("rst");

        xfer(0, 12'h000, 0, 0, 0, rd, er);
        chk("tcr_reset_read", 64'(rd), 64'h0000_0100);
        xfer(0, 12'h00C, 0, 0, 0, rd, er);
        chk("tcmp0_reset_read", 64'(rd), 64'hFFFF_FFFF);

        xfer(1, 12'h00C, 32'h1234_5678, 4'b0011, 0, rd, er);
        xfer(0, 12'h00C, 0, 0, 0, rd, er);
        chk("tcmp0_strobe", 64'(rd), 64'hFFFF_5678);

        xfer(1, 12'h000, 32'h0000_0903, 4'hF, 0, rd, er);
        chk("tcr_div9_err", 64'(er), 64'd1);
        xfer(0, 12'h000, 0, 0, 0, rd, er);
        chk("tcr_after_err", 64'(rd), 64'h0000_0100);
        xfer(1, 12'h000, 32'h0000_0803, 4'hF, 0, rd, er);
        chk("tcr_div8_ok", 64'(er), 64'd0);
        xfer(1, 12'h000, 32'h0000_0301, 4'hF, 0, rd, er);
        chk("tcr_locked_err", 64'(er), 64'd1);
        xfer(1, 12'h000, 32'h0000_0802, 4'hF, 0, rd, er);
        check_outputs("tcr");

        xfer(1, 12'h014, 32'h1, 4'h1, 0, rd, er);
        #1 int_set = 1;
        @(posedge sys_clk); #1 int_set = 0;
        m_tisr = 1;
        @(negedge sys_clk);
        chk("tim_int_after_set", 64'(tim_int), 64'd1);
        xfer(1, 12'h018, 32'h1, 4'h1, 1, rd, er);
        xfer(0, 12'h018, 0, 0, 0, rd, er);
        chk("tisr_set_wins", 64'(rd), 64'd1);
        xfer(1, 12'h018, 32'h1, 4'h1, 0, rd, er);
        check_outputs("w1c");

        xfer(1, 12'h01C, 32'h1, 4'h1, 0, rd, er);
        chk("halt_ack_nodbg", 64'(halt_ack), 64'd0);
        dbg_mode = 1;
        #1 chk("halt_ack_dbg", 64'(halt_ack), 64'd1);
        xfer(0, 12'h01C, 0, 0, 0, rd, er);
        chk("thcsr_read", 64'(rd), 64'h3);

        // Abort after setup: the write must not land and no pready appears.
        @(posedge sys_clk); #1;
        bus.tim_psel = 1; bus.tim_penable = 0; bus.tim_pwrite = 1;
        bus.tim_paddr = 12'h010; bus.tim_pwdata = 32'hDEAD_BEEF; bus.tim_pstrb = 4'hF;
        @(posedge sys_clk); #1 bus.tim_psel = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            chk("abort_pready", 64'(bus.tim_pready), 64'd0);
        end
        check_outputs("abort");

        // Reset during the access phase.
        xfer(1, 12'h010, 32'hAAAA_5555, 4'hF, 0, rd, er);
        @(posedge sys_clk); #1;
        bus.tim_psel = 1; bus.tim_penable = 0; bus.tim_pwrite = 1;
        bus.tim_paddr = 12'h010; bus.tim_pwdata = 32'h1111_2222; bus.tim_pstrb = 4'hF;
        @(posedge sys_clk); #1 bus.tim_penable = 1;
        @(negedge sys_clk);
        chk("midrst_pready_pre", 64'(bus.tim_pready), 64'd0);
        sys_rst_n = 0;
        @(negedge sys_clk);
        chk("midrst_pready", 64'(bus.tim_pready), 64'd0);
        chk("midrst_cnt_wr", 64'({cnt_wr_lo, cnt_wr_hi}), 64'd0);
        bus.tim_psel = 0; bus.tim_penable = 0;
        @(posedge sys_clk); #1 sys_rst_n = 1;
        model_reset();
        check_outputs("midrst");
        xfer(0, 12'h010, 0, 0, 0, rd, er);
        chk("midrst_tcmp1", 64'(rd), 64'hFFFF_FFFF);

        addrs = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014,
                  12'h018, 12'h01C, 12'h020, 12'h400, 12'hFFC};
        for (int i = 0; i < 60; i++) begin
            logic [11:0] a;
            logic [31:0] d;
            a = addrs[$urandom_range(0, 10)] | 12'($urandom_range(0, 3));
            d = $urandom;
            if (a[11:2] == 10'd0) d = d & 32'h0000_0F03;
            dbg_mode = 1'($urandom_range(0, 1));
            cnt_val  = {$urandom, $urandom};
            xfer(1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)), 0, rd, er);
            check_outputs("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
